stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 163 ++++++++++++++++
 tb/tb_stream_mux_rr.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel packet stream multiplexer with an internal round-robin or fixed-priority
// arbiter. The grant is held for a whole packet, and the output stage is registered with a valid/ready handshake.
module stream_mux_rr #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int MODE   = 0,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready,
    output logic                     busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;

    logic               slot_free_s;
    logic               xfer_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               sel_last_s;
    logic [SEL_W-1:0]   winner_s;

    // First requester after ptr, scanning upward with wrap-around.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [SEL_W-1:0]  ptr);
        logic [SEL_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!found && req[idx]) begin
                win   = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [SEL_W-1:0] fp_pick(input logic [NUM_CH-1:0] req);
        logic [SEL_W-1:0] win;
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = SEL_W'(i);
            end
        end
        return win;
    endfunction

    assign slot_free_s = ~out_valid_q | out_ready;
    assign sel_data_s  = in_data[grant_q*DATA_W +: DATA_W];
    assign sel_last_s  = in_last[grant_q];
    assign xfer_s      = (state_q == ST_LOCKED) & slot_free_s & in_valid[grant_q];
    assign winner_s    = (MODE == 0) ? rr_pick(in_valid, rr_ptr_q) : fp_pick(in_valid);

    // Only the locked channel may be accepted, and only while the output slot can take a beat.
    always_comb begin
        in_ready = '0;
        if ((state_q == ST_LOCKED) && slot_free_s) begin
            in_ready[grant_q] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Arbitration FSM plus output-stage load/drain.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;

        case (state_q)
            ST_IDLE: begin
                if (|in_valid) begin
                    grant_d = winner_s;
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && sel_last_s) begin
                    state_d = ST_IDLE;
                    if (MODE == 0) begin
                        rr_ptr_d = grant_q;
                    end else begin
                        rr_ptr_d = rr_ptr_q;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load on the same edge as a drain wins, keeping out_valid high.
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_last_d  = sel_last_s;
            out_ch_d    = grant_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= SEL_W'(NUM_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: four instances (RR 8x8, fixed-priority 8x8, RR 3x16, RR 2x1)
// fed by per-channel packet sources; a negedge monitor pops expected beats as the DUTs emit them.
module tb_stream_mux_rr;

    localparam int ND    = 4;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source storage: {last, data[15:0]} per beat, per channel, per DUT.
    logic [16:0] mem [ND][8][DEPTH];
    int          wr  [ND][8];
    int          rd  [ND][8];
    bit          en  [ND][8];
    logic [7:0]  iv  [ND];
    logic [7:0]  il  [ND];
    logic [7:0]  hsv [ND];
    logic [63:0] da, db;
    logic [47:0] dc;
    logic [1:0]  dd;

    logic [7:0]  ir   [ND];
    logic        ov   [ND];
    logic        ol   [ND];
    logic [15:0] od   [ND];
    logic [2:0]  oc   [ND];
    logic        bz   [ND];
    logic        ordy [ND];

    logic [7:0]  ir_a, ir_b, od_a, od_b;
    logic [2:0]  ir_c, oc_a, oc_b;
    logic [1:0]  ir_d, oc_c;
    logic [15:0] od_c;
    logic        od_d, oc_d, or_a;

    assign ir[0] = ir_a;               assign ir[1] = ir_b;
    assign ir[2] = {5'b0, ir_c};       assign ir[3] = {6'b0, ir_d};
    assign od[0] = {8'b0, od_a};       assign od[1] = {8'b0, od_b};
    assign od[2] = od_c;               assign od[3] = {15'b0, od_d};
    assign oc[0] = oc_a;               assign oc[1] = oc_b;
    assign oc[2] = {1'b0, oc_c};       assign oc[3] = {2'b0, oc_d};
    assign ordy[0] = or_a;             assign ordy[1] = 1'b1;
    assign ordy[2] = 1'b1;             assign ordy[3] = 1'b1;

    always_comb begin
        da = '0; db = '0; dc = '0; dd = '0;
        for (int d = 0; d < ND; d++) begin
            iv[d] = '0;
            il[d] = '0;
            for (int c = 0; c < 8; c++) begin
                iv[d][c] = en[d][c] && (rd[d][c] < wr[d][c]);
                il[d][c] = mem[d][c][rd[d][c] % DEPTH][16];
            end
        end
        for (int c = 0; c < 8; c++) begin
            da[c*8 +: 8] = mem[0][c][rd[0][c] % DEPTH][7:0];
            db[c*8 +: 8] = mem[1][c][rd[1][c] % DEPTH][7:0];
        end
        for (int c = 0; c < 3; c++) dc[c*16 +: 16] = mem[2][c][rd[2][c] % DEPTH][15:0];
        for (int c = 0; c < 2; c++) dd[c] = mem[3][c][rd[3][c] % DEPTH][0];
    end

    stream_mux_rr #(.NUM_CH(8), .DATA_W(8), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(da), .in_last(il[0]),
        .in_ready(ir_a), .out_valid(ov[0]), .out_data(od_a), .out_last(ol[0]),
        .out_ch(oc_a), .out_ready(or_a), .busy(bz[0]));
    stream_mux_rr #(.NUM_CH(8), .DATA_W(8), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(db), .in_last(il[1]),
        .in_ready(ir_b), .out_valid(ov[1]), .out_data(od_b), .out_last(ol[1]),
        .out_ch(oc_b), .out_ready(1'b1), .busy(bz[1]));
    stream_mux_rr #(.NUM_CH(3), .DATA_W(16), .MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2][2:0]), .in_data(dc), .in_last(il[2][2:0]),
        .in_ready(ir_c), .out_valid(ov[2]), .out_data(od_c), .out_last(ol[2]),
        .out_ch(oc_c), .out_ready(1'b1), .busy(bz[2]));
    stream_mux_rr #(.NUM_CH(2), .DATA_W(1), .MODE(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3][1:0]), .in_data(dd), .in_last(il[3][1:0]),
        .in_ready(ir_d), .out_valid(ov[3]), .out_data(od_d), .out_last(ol[3]),
        .out_ch(oc_d), .out_ready(1'b1), .busy(bz[3]));

    // Sources advance past a beat once it was handshaken at the preceding edge.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) hsv[d] = iv[d] & ir[d];
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < 8; c++)
                if (hsv[d][c]) rd[d][c]++;
    end

    // Sink for DUT A: 0 = always ready, 1 = pattern 1,0,0,1,..., 2 = never ready.
    int or_mode = 0;
    int bp_cnt  = 0;
    initial begin
        or_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                1: begin
                    or_a = !(((bp_cnt % 4) == 1) || ((bp_cnt % 4) == 2));
                    bp_cnt++;
                end
                2:       or_a = 1'b0;
                default: or_a = 1'b1;
            endcase
        end
    end

    logic [19:0] exq0[$], exq1[$], exq2[$], exq3[$];
    int          last_pop [ND];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return exq0.size();
            1:       return exq1.size();
            2:       return exq2.size();
            default: return exq3.size();
        endcase
    endfunction

    task automatic expect_beat(input int d, input int c, input logic last, input logic [15:0] data);
        logic [19:0] v;
        v = {3'(c), last, data};
        case (d)
            0:       exq0.push_back(v);
            1:       exq1.push_back(v);
            2:       exq2.push_back(v);
            default: exq3.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int d, output logic [19:0] v);
        case (d)
            0:       v = exq0.pop_front();
            1:       v = exq1.pop_front();
            2:       v = exq2.pop_front();
            default: v = exq3.pop_front();
        endcase
    endtask

    task automatic put(input int d, input int c, input logic [15:0] data, input logic last);
        mem[d][c][wr[d][c] % DEPTH] = {last, data};
        wr[d][c]++;
    endtask

    task automatic wait_empty(input int d, input int lim);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (qsize(d) != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_dut%0d: %0d beats outstanding, expected 0", d, qsize(d));
        end
    endtask

    // Monitor: scoreboard pops, one-hot in_ready, stall behaviour of DUT A.
    initial begin
        logic [19:0] got, exp, held;
        bit          stall_prev;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < ND; d++) begin
                    check($sformatf("onehot_ready_dut%0d", d), 32'($countones(ir[d]) <= 1), 32'd1);
                    if (ov[d] && ordy[d]) begin
                        got = {oc[d], ol[d], od[d]};
                        if (qsize(d) == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL spurious_beat_dut%0d: got 0x%0h, expected no beat", d, got);
                        end else begin
                            pop_exp(d, exp);
                            check($sformatf("beat_dut%0d", d), 32'(got), 32'(exp));
                            last_pop[d] = cyc;
                        end
                    end
                end
                if (stall_prev) check("hold_during_stall", 32'({oc[0], ol[0], od[0]}), 32'(held));
                if (ov[0] && !ordy[0]) begin
                    check("ready_low_while_stalled", 32'(ir[0]), 32'd0);
                    stall_prev = 1'b1;
                    held       = {oc[0], ol[0], od[0]};
                end else begin
                    stall_prev = 1'b0;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        int t0, n;
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < 8; c++) en[d][c] = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(ov[0]), 32'd0);
        check("reset_out_data",  32'(od[0]), 32'd0);
        check("reset_out_last",  32'(ol[0]), 32'd0);
        check("reset_out_ch",    32'(oc[0]), 32'd0);
        check("reset_busy",      32'(bz[0]), 32'd0);
        check("reset_in_ready",  32'(ir[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin on A, fixed priority on B, width sweeps on C and D, all at once.
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++)
                for (int b = 0; b < 2; b++) begin
                    put(0, c, 16'(c * 16 + r * 2 + b), b == 1);
                    expect_beat(0, c, b == 1, 16'(c * 16 + r * 2 + b));
                end
        for (int i = 0; i < 3; i++) put(1, 2, 16'(8'h20 + i), 1'b1);
        for (int i = 0; i < 2; i++) put(1, 5, 16'(8'h50 + i), 1'b1);
        for (int i = 0; i < 3; i++) expect_beat(1, 2, 1'b1, 16'(8'h20 + i));
        for (int i = 0; i < 2; i++) expect_beat(1, 5, 1'b1, 16'(8'h50 + i));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) begin
                put(2, c, 16'(16'hC000 + c * 256 + r), 1'b1);
                expect_beat(2, c, 1'b1, 16'(16'hC000 + c * 256 + r));
            end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int b = 0; b < 2; b++) begin
                    put(3, c, 16'(b ^ c), b == 1);
                    expect_beat(3, c, b == 1, 16'(b ^ c));
                end
        wait_empty(0, 200);
        check("rr_16_packets_cycles", 32'(last_pop[0] - t0), 32'd48);
        for (int d = 1; d < ND; d++) wait_empty(d, 50);

        // Backpressure: 4-beat packet on ch1 under a toggling sink.
        @(posedge clk);
        #1;
        or_mode = 1;
        bp_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            put(0, 1, 16'(8'hA1 + i), i == 3);
            expect_beat(0, 1, i == 3, 16'(8'hA1 + i));
        end
        wait_empty(0, 100);
        or_mode = 0;
        repeat (3) @(posedge clk);

        // Lock: ch0 3-beat packet with a gap after beat 1 while ch4 requests.
        #1;
        put(0, 0, 16'h01, 1'b0);
        put(0, 0, 16'h02, 1'b0);
        put(0, 0, 16'h03, 1'b1);
        expect_beat(0, 0, 1'b0, 16'h01);
        expect_beat(0, 0, 1'b0, 16'h02);
        expect_beat(0, 0, 1'b1, 16'h03);
        expect_beat(0, 4, 1'b1, 16'h44);
        @(posedge clk);
        #1;
        put(0, 4, 16'h44, 1'b1);
        @(posedge clk);
        #1;
        en[0][0] = 1'b0;
        @(negedge clk);
        check("lock_gap_busy",        32'(bz[0]), 32'd1);
        check("lock_gap_ch4_ready",   32'(ir[0][4]), 32'd0);
        check("lock_gap_ch0_ready",   32'(ir[0][0]), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        en[0][0] = 1'b1;
        wait_empty(0, 50);

        // Reset mid-packet with a stalled output beat.
        @(posedge clk);
        #1;
        or_mode = 2;
        put(0, 6, 16'h61, 1'b0);
        put(0, 6, 16'h62, 1'b0);
        put(0, 6, 16'h63, 1'b1);
        n = 0;
        while (!ov[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        en[0][6] = 1'b0;
        check("pre_reset_out_valid", 32'(ov[0]), 32'd1);
        check("pre_reset_busy",      32'(bz[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(ov[0]), 32'd0);
        check("async_reset_busy",      32'(bz[0]), 32'd0);
        check("async_reset_in_ready",  32'(ir[0]), 32'd0);
        or_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        put(0, 3, 16'h33, 1'b1);
        expect_beat(0, 3, 1'b1, 16'h33);
        wait_empty(0, 20);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
